// File: rtl/maxnet_register_bank_if.sv
// Bus bundle for maxnet_register_bank: load/clear controls, channel data,
// convergence status and winner flags. master drives, slave is the bank.
interface maxnet_register_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic                      clear;
    logic                      load;
    logic [CHANNELS-1:0]       load_mask;
    logic [CHANNELS*WIDTH-1:0] input_data;
    logic [CHANNELS*WIDTH-1:0] output_data;
    logic                      changed;
    logic                      stable;
    logic [CHANNELS-1:0]       nonzero;
    logic                      single_nonzero;
    logic [CNT_W-1:0]          load_count;

    modport master (
        output clear, load, load_mask, input_data,
        input  output_data, changed, stable, nonzero,
        input  single_nonzero, load_count
    );

    modport slave (
        input  clear, load, load_mask, input_data,
        output output_data, changed, stable, nonzero,
        output single_nonzero, load_count
    );
endinterface

// File: rtl/maxnet_register_bank.sv
// Multi-channel Maxnet load register bank with change/convergence tracking.
// Ports: clock, reset (async active-low), bus (slave side of the bank bundle).
module maxnet_register_bank #(
    parameter int WIDTH        = 32,
    parameter int CHANNELS     = 4,
    parameter int STABLE_LOADS = 2,
    parameter int CNT_W        = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    maxnet_register_bank_if.slave bus
);
    localparam int SC_W = $clog2(STABLE_LOADS + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_LOADS);

    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS*WIDTH-1:0] data_d;
    logic                      changed_q;
    logic                      stable_q;
    logic [SC_W-1:0]           sc_q;
    logic [SC_W-1:0]           sc_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      diff;
    logic                      effective;
    logic [CHANNELS-1:0]       nz;

    // A masked-off load is a pure no-op; clear swallows any load.
    assign effective = bus.load && (|bus.load_mask) && !bus.clear;

    always_comb begin
        data_d = data_q;
        diff   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.load_mask[i]) begin
                data_d[i*WIDTH +: WIDTH] = bus.input_data[i*WIDTH +: WIDTH];
                if (bus.input_data[i*WIDTH +: WIDTH] != data_q[i*WIDTH +: WIDTH])
                    diff = 1'b1;
            end
        end
    end

    always_comb begin
        sc_d = sc_q;
        if (diff)
            sc_d = '0;
        else if (sc_q != SC_MAX)
            sc_d = sc_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b0;
            sc_q      <= '0;
            cnt_q     <= '0;
        end else if (bus.clear) begin
            data_q    <= '0;
            changed_q <= 1'b0;
            stable_q  <= 1'b0;
            sc_q      <= '0;
            cnt_q     <= '0;
        end else if (effective) begin
            data_q    <= data_d;
            changed_q <= diff;
            sc_q      <= sc_d;
            stable_q  <= (sc_d == SC_MAX);
            if (!(&cnt_q))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        nz = '0;
        for (int i = 0; i < CHANNELS; i++)
            nz[i] = |data_q[i*WIDTH +: WIDTH];
    end

    assign bus.output_data    = data_q;
    assign bus.changed        = changed_q;
    assign bus.stable         = stable_q;
    assign bus.load_count     = cnt_q;
    assign bus.nonzero        = nz;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign bus.single_nonzero = (nz != '0) && ((nz & (nz - 1'b1)) == '0);
endmodule

// File: tb/tb_maxnet_register_bank.sv
// Directed bench for maxnet_register_bank: default instance plus a
// CNT_W=2 instance for load_count saturation.
module tb_maxnet_register_bank;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    maxnet_register_bank_if #(.WIDTH(32), .CHANNELS(4), .CNT_W(8)) bus ();
    maxnet_register_bank_if #(.WIDTH(32), .CHANNELS(4), .CNT_W(2)) bus2 ();

    maxnet_register_bank #(
        .WIDTH(32), .CHANNELS(4), .STABLE_LOADS(2), .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    maxnet_register_bank #(
        .WIDTH(32), .CHANNELS(4), .STABLE_LOADS(2), .CNT_W(2)
    ) dut2 (
        .clock(clock),
        .reset(reset),
        .bus(bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] m, input logic [127:0] d);
        bus.load       = 1'b1;
        bus.load_mask  = m;
        bus.input_data = d;
        step();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.output_data !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", bus.output_data);
        end
        checks++;
        if ({bus.changed, bus.stable, bus.single_nonzero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000",
                     {bus.changed, bus.stable, bus.single_nonzero});
        end
        checks++;
        if (bus.load_count !== 8'd0 || bus.nonzero !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got %0d/%b expected 0/0000",
                     bus.load_count, bus.nonzero);
        end
        step();
        reset = 1'b1;
    endtask

    task automatic test_load();
        drive(4'hF, {32'd3, 32'd2, 32'd1, 32'd0});
        checks++;
        if (bus.output_data !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL load_data got %h expected 3/2/1/0", bus.output_data);
        end
        checks++;
        if ({bus.changed, bus.stable} !== 2'b10 || bus.load_count !== 8'd1) begin
            errors++;
            $display("FAIL load_flags got c=%b s=%b n=%0d expected c=1 s=0 n=1",
                     bus.changed, bus.stable, bus.load_count);
        end
        checks++;
        if (bus.nonzero !== 4'b1110 || bus.single_nonzero !== 1'b0) begin
            errors++;
            $display("FAIL load_nonzero got %b/%b expected 1110/0",
                     bus.nonzero, bus.single_nonzero);
        end
    endtask

    task automatic test_masked_load();
        drive(4'b0010, {4{32'hFFFF_FFFF}});
        checks++;
        if (bus.output_data !== {32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0}) begin
            errors++;
            $display("FAIL masked_data got %h expected 3/2/FFFFFFFF/0",
                     bus.output_data);
        end
        checks++;
        if (bus.changed !== 1'b1 || bus.load_count !== 8'd2) begin
            errors++;
            $display("FAIL masked_flags got c=%b n=%0d expected c=1 n=2",
                     bus.changed, bus.load_count);
        end
        drive(4'b0000, {4{32'hAAAA_5555}});
        checks++;
        if (bus.output_data !== {32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0}) begin
            errors++;
            $display("FAIL nomask_data got %h expected 3/2/FFFFFFFF/0",
                     bus.output_data);
        end
        checks++;
        if (bus.changed !== 1'b1 || bus.load_count !== 8'd2) begin
            errors++;
            $display("FAIL nomask_flags got c=%b n=%0d expected c=1 n=2",
                     bus.changed, bus.load_count);
        end
    endtask

    task automatic test_convergence();
        drive(4'hF, {32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0});
        checks++;
        if ({bus.changed, bus.stable} !== 2'b00 || bus.load_count !== 8'd3) begin
            errors++;
            $display("FAIL conv1 got c=%b s=%b n=%0d expected c=0 s=0 n=3",
                     bus.changed, bus.stable, bus.load_count);
        end
        drive(4'hF, {32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0});
        checks++;
        if ({bus.changed, bus.stable} !== 2'b01 || bus.load_count !== 8'd4) begin
            errors++;
            $display("FAIL conv2 got c=%b s=%b n=%0d expected c=0 s=1 n=4",
                     bus.changed, bus.stable, bus.load_count);
        end
        drive(4'hF, {32'd3, 32'd2, 32'hFFFF_FFFF, 32'd5});
        checks++;
        if ({bus.changed, bus.stable} !== 2'b10 || bus.load_count !== 8'd5) begin
            errors++;
            $display("FAIL conv3 got c=%b s=%b n=%0d expected c=1 s=0 n=5",
                     bus.changed, bus.stable, bus.load_count);
        end
    endtask

    task automatic test_winner();
        drive(4'hF, {32'd0, 32'd0, 32'd7, 32'd0});
        checks++;
        if (bus.nonzero !== 4'b0010 || bus.single_nonzero !== 1'b1) begin
            errors++;
            $display("FAIL winner got %b/%b expected 0010/1",
                     bus.nonzero, bus.single_nonzero);
        end
        drive(4'hF, 128'd0);
        checks++;
        if (bus.nonzero !== 4'b0000 || bus.single_nonzero !== 1'b0 ||
            bus.changed !== 1'b1) begin
            errors++;
            $display("FAIL all_zero got %b/%b c=%b expected 0000/0 c=1",
                     bus.nonzero, bus.single_nonzero, bus.changed);
        end
        drive(4'hF, 128'd0);
        checks++;
        if (bus.changed !== 1'b0 || bus.load_count !== 8'd8) begin
            errors++;
            $display("FAIL zero_reload got c=%b n=%0d expected c=0 n=8",
                     bus.changed, bus.load_count);
        end
    endtask

    task automatic test_clear_priority();
        drive(4'hF, {32'd1, 32'd0, 32'd0, 32'd0});
        bus.clear = 1'b1;
        drive(4'hF, {4{32'd9}});
        bus.clear = 1'b0;
        checks++;
        if (bus.output_data !== 128'd0 || bus.nonzero !== 4'd0) begin
            errors++;
            $display("FAIL clear_data got %h expected 0", bus.output_data);
        end
        checks++;
        if ({bus.changed, bus.stable} !== 2'b00 || bus.load_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_flags got c=%b s=%b n=%0d expected 0/0/0",
                     bus.changed, bus.stable, bus.load_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cs [3];
        logic [2:0] got;
        exp_cs[0] = 3'b100;
        exp_cs[1] = 3'b000;
        exp_cs[2] = 3'b010;
        bus.load       = 1'b1;
        bus.load_mask  = 4'hF;
        bus.input_data = {4{32'd1}};
        for (int k = 0; k < 3; k++) begin
            step();
            got = {bus.changed, bus.stable, 1'b0};
            checks++;
            if (got !== exp_cs[k] || bus.load_count !== 8'(k + 1)) begin
                errors++;
                $display("FAIL b2b_%0d got cs=%b n=%0d expected cs=%b n=%0d",
                         k, got, bus.load_count, exp_cs[k], k + 1);
            end
        end
        bus.load = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.output_data !== 128'd0 || bus.load_count !== 8'd0 ||
            bus.stable !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got d=%h n=%0d s=%b expected 0",
                     bus.output_data, bus.load_count, bus.stable);
        end
        step();
        reset = 1'b1;
        drive(4'hF, {4{32'd1}});
        drive(4'hF, {4{32'd1}});
        checks++;
        if ({bus.changed, bus.stable} !== 2'b00 || bus.load_count !== 8'd2) begin
            errors++;
            $display("FAIL reset_restart got c=%b s=%b n=%0d expected 0/0/2",
                     bus.changed, bus.stable, bus.load_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_n [5];
        exp_n[0] = 2'd1;
        exp_n[1] = 2'd2;
        exp_n[2] = 2'd3;
        exp_n[3] = 2'd3;
        exp_n[4] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            bus2.load       = 1'b1;
            bus2.load_mask  = 4'b0001;
            bus2.input_data = 128'(k + 1);
            step();
            bus2.load = 1'b0;
            checks++;
            if (bus2.load_count !== exp_n[k]) begin
                errors++;
                $display("FAIL sat_%0d got %0d expected %0d",
                         k, bus2.load_count, exp_n[k]);
            end
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b0;
        bus.clear       = 1'b0;
        bus.load        = 1'b0;
        bus.load_mask   = '0;
        bus.input_data  = '0;
        bus2.clear      = 1'b0;
        bus2.load       = 1'b0;
        bus2.load_mask  = '0;
        bus2.input_data = '0;
        test_reset();
        test_load();
        test_masked_load();
        test_convergence();
        test_winner();
        test_clear_priority();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
